dp_scan: RTL
============

# dp_scan

Multiplexed display scanner: latches a multi-digit hex value, time-multiplexes it onto a bank of 7-segment digits, and drives one digit at a time. Sits directly upstream of the single-digit segment decoders. Its `num` output feeds the decoder's 4-bit nibble input, and its `sel` output drives the digit enables. Inserts a dead-time gap between digits to prevent ghosting and optionally suppresses leading zeros.

## Interface

Parameters:

- `DIGITS`, 4: number of digits scanned (≥ 2).
- `SHOW_CYC`, 50000: clock cycles each digit is driven (≥ 1).
- `GAP_CYC`, 500: dead-time cycles between digits, all selects inactive (≥ 1).
- `SEL_ACTIVE_LOW`, 1: 1 means a driven digit's `sel` bit is 0; 0 means it is 1.

Ports:

- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `value`, in, 4*DIGITS: hex digits; digit i is `value[4i+3:4i]`; digit 0 is least significant.
- `load`, in, 1: when high at a rising edge, the shadow register captures `value`.
- `lz_en`, in, 1: enables leading-zero suppression.
- `num`, out, 4: nibble of the currently driven digit, to the decoder.
- `sel`, out, DIGITS: one-hot digit enable, polarity per `SEL_ACTIVE_LOW`.
- `blank`, out, 1: 1 means the downstream decoder output is forced dark.
- `frame_tick`, out, 1: one-cycle pulse at the end of each full scan.

## Operation

- Shadow register `shadow` (4*DIGITS bits): cleared by reset and written on `load`. The scan reads only `shadow`, never `value` directly.
- FSM has two states, GAP and SHOW. Counters: `cnt` (width `$clog2(max(SHOW_CYC,GAP_CYC))`) and digit index `idx` (width `$clog2(DIGITS)`).
  - GAP: all `sel` bits inactive, `blank`=1, `num` holds its last value. After GAP_CYC cycles the FSM enters SHOW for `idx`.
  - SHOW: `sel[idx]` is active, `num`=`shadow` digit `idx`, `blank`=0, unless that digit is suppressed. After SHOW_CYC cycles the FSM enters GAP and `idx` increments, wrapping from DIGITS-1 to 0.
- Leading-zero suppression: digit i (i ≥ 1) is suppressed when `lz_en`=1 and every shadow digit from DIGITS-1 down to i is 0. Digit 0 is never suppressed.
  - A suppressed digit's SHOW slot keeps full length, with all `sel` inactive and `blank`=1.
- `num`, `sel` and `blank` are registered. They change only on GAP↔SHOW transitions, so a `load` or `lz_en` change mid-digit takes effect at the next SHOW entry. No mid-digit glitch is allowed.
- `frame_tick`=1 during the last SHOW cycle of digit DIGITS-1 only.

## Timing

- Reset values: `state`=GAP, `cnt`=0, `idx`=0, `shadow`=0, `num`=0, `sel`=all inactive, `blank`=1, `frame_tick`=0.
- Cycle 0 is the first cycle with `rst` low. Cycles 0..GAP_CYC-1 are GAP. Digit 0 is shown during cycles GAP_CYC..GAP_CYC+SHOW_CYC-1.
- Digit period is SHOW_CYC+GAP_CYC cycles; frame period is DIGITS*(SHOW_CYC+GAP_CYC) cycles.
- `load` latency: the shadow register is updated one edge after `load`. The new value becomes visible at the first SHOW entry after that edge.
- `load` held high: the shadow register follows `value` every cycle.
- `rst` asserted mid-scan: at the next edge all state returns to its reset values, regardless of FSM state.

## Structure

- Shared package `dp_pkg` holds the state typedef (`DP_GAP`, `DP_SHOW`) and default constants for SHOW_CYC and GAP_CYC.
- One combinational sub-module, `dp_lz_mask`, computes the DIGITS-bit suppression mask from `shadow` and `lz_en`.
- Counters and the FSM stay in `dp_scan`.

## Test plan

All scenarios use DIGITS=4, SHOW_CYC=3, GAP_CYC=1, SEL_ACTIVE_LOW=1.

- **Reset:** hold `rst` for 2 cycles → `sel`=4'b1111, `blank`=1, `num`=0. Cycle 1 after release → `sel`=4'b1110, `num`=shadow digit 0 (0), held for 3 cycles.
- **Basic scan:** `load` with `value`=16'h4B7A, `lz_en`=0 → `num` sequence A,7,B,4, with `sel` 1110,1101,1011,0111. Each digit lasts 3 cycles, separated by 1 cycle of `sel`=1111. `frame_tick` pulses every 16 cycles.
- **Leading-zero suppression:** `value`=16'h0050, `lz_en`=1 → digits 3 and 2 show `blank`=1 and `sel`=1111; digits 1 (5) and 0 (0) are driven. `value`=16'h0000 → only digit 0 is driven, showing 0.
- **Mid-digit load:** `load` of 16'h1111 at the 2nd cycle of digit 1's SHOW → `num` is unchanged for the rest of that slot; digit 2 shows 1.
- **Reset mid-operation:** assert `rst` during digit 2's SHOW → next edge gives `sel`=1111, `shadow`=0. The scan restarts at digit 0 after 1 GAP cycle.
- **Wrap:** run 3 frames → `idx` wraps 3→0 with no extra cycles. `frame_tick` spacing is exactly 16 cycles.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and defaults for the multiplexed display scanner.
package dp_pkg;

  typedef enum logic {
    DP_GAP  = 1'b0,
    DP_SHOW = 1'b1
  } dp_state_e;

  localparam int DP_SHOW_CYC_DEF = 50000;
  localparam int DP_GAP_CYC_DEF  = 500;

  // Counter width covering both phases; never narrower than one bit.
  function automatic int dp_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dp_lz_mask.sv
// Leading-zero mask: bit i set when digit i and every digit above it are zero.
// Purely combinational; digit 0 is never masked.
module dp_lz_mask
  import dp_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] shadow,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   mask
);

  logic all_zero;

  always_comb begin
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (shadow[4*i +: 4] == 4'h0);
      mask[i]  = lz_en & all_zero;
    end
  end

endmodule

// File: rtl/dp_scan.sv
// Multiplexed 7-segment scanner: shadow-latched value, SHOW/GAP time slicing.
// Outputs are registered and change only on phase transitions; no backpressure.
module dp_scan
  import dp_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SHOW_CYC       = DP_SHOW_CYC_DEF,
  parameter int GAP_CYC        = DP_GAP_CYC_DEF,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic                lz_en,
  output logic [3:0]          num,
  output logic [DIGITS-1:0]   sel,
  output logic                blank,
  output logic                frame_tick
);

  localparam int CNT_W = dp_cnt_w(SHOW_CYC, GAP_CYC);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

  dp_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]          num_q, num_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                blank_q, blank_d;
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   sel_on;

  dp_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .shadow (shadow_q),
    .lz_en  (lz_en),
    .mask   (lz_mask)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    num_d    = num_q;
    sel_d    = sel_q;
    blank_d  = blank_q;
    shadow_d = load ? value : shadow_q;
    sel_on   = DIGITS'(1) << idx_q;

    case (state_q)
      DP_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = DP_SHOW;
          cnt_d   = '0;
          // Digit content and suppression are frozen here for the whole slot.
          if (lz_mask[idx_q]) begin
            sel_d   = SEL_OFF;
            blank_d = 1'b1;
          end else begin
            sel_d   = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
            num_d   = shadow_q[4*idx_q +: 4];
            blank_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DP_SHOW: begin
        if (cnt_q == CNT_W'(SHOW_CYC - 1)) begin
          state_d = DP_GAP;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
          sel_d   = SEL_OFF;
          blank_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DP_GAP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DP_GAP;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      num_q    <= 4'h0;
      sel_q    <= SEL_OFF;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      num_q    <= num_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
    end
  end

  assign num        = num_q;
  assign sel        = sel_q;
  assign blank      = blank_q;
  assign frame_tick = (state_q == DP_SHOW) &&
                      (idx_q == IDX_W'(DIGITS - 1)) &&
                      (cnt_q == CNT_W'(SHOW_CYC - 1));

endmodule
